sd_cmd_engine: RTL and testbench

- Hardware SD command-line engine; replaces CPU bit-banging of SD_CLK/SD_CMD for command/response phases.
- CPU-bus slave upstream (same i_request/i_rw/o_ready handshake as other peripherals); drives the SD card pins downstream.
- Serialises a 48-bit command with generated CRC7, optionally captures the 48-bit response, and reports status.

---
 rtl/sd_cmd_engine.sv | 273 +++++++++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_engine.sv
// SD command-line engine: 48-bit command out with CRC7, optional 48-bit response in.
// Define SD_CMD_RESP_CRC_EN to check the CRC7 of received responses.
module sd_cmd_engine #(
  parameter logic [7:0] DEFAULT_DIV  = 8'd124,
  parameter int         RESP_TIMEOUT = 64,
  parameter int         NCC_CLOCKS   = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [1:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        SD_CLK,
  output logic        SD_CMD_out,
  output logic        SD_CMD_oe,
  input  logic        SD_CMD_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SEND, S_WAIT, S_RECV, S_NCC
  } state_t;

  localparam logic [6:0] INIT_LAST = 7'd80;
  localparam logic [6:0] NCC_LAST  = 7'(NCC_CLOCKS);
  localparam logic [6:0] TO_LAST   = 7'(RESP_TIMEOUT - 1);

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        sdclk_q, sdclk_d;
  logic        cmd_out_q, cmd_out_d;
  logic        cmd_oe_q, cmd_oe_d;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic [47:0] shreg_q, shreg_d;
  logic [31:0] arg_q, arg_d;
  logic [7:0]  div_q, div_d;
  logic [31:0] resp_q, resp_d;
  logic [5:0]  resp_idx_q, resp_idx_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        crc_err_q, crc_err_d;
  logic        resp_en_q, resp_en_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;

  logic        busy, tick, rise, fall, wr_idle, resp_bad;
  logic [39:0] hdr;
  logic [47:0] frame, rx;
  logic [31:0] status, rd_mux;
  logic        unused_shreg;

  assign busy    = (state_q != S_IDLE);
  assign tick    = busy && (div_cnt_q == div_q);
  assign rise    = tick && !sdclk_q;
  assign fall    = tick && sdclk_q;
  assign wr_idle = i_request && i_rw && !busy;
  assign hdr     = {2'b01, i_wdata[5:0], arg_q};
  assign frame   = {hdr, crc7(hdr), 1'b1};
  assign rx      = {shreg_q[46:0], SD_CMD_in};
  assign unused_shreg = shreg_q[47];

`ifdef SD_CMD_RESP_CRC_EN
  assign resp_bad = ~rx[0] | (crc7(rx[47:8]) != rx[7:1]);
`else
  logic unused_rx;
  assign unused_rx = ^{rx[47:46], rx[7:1]};
  assign resp_bad  = ~rx[0];
`endif

  assign status = {10'b0, resp_idx_q, 12'b0,
                   crc_err_q, timeout_q, done_q, busy};

  always_comb begin
    rd_mux = '0;
    unique case (i_address)
      2'd0: rd_mux = arg_q;
      2'd1: rd_mux = status;
      2'd2: rd_mux = resp_q;
      2'd3: rd_mux = {24'b0, div_q};
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    sdclk_d    = sdclk_q;
    cmd_out_d  = cmd_out_q;
    cmd_oe_d   = cmd_oe_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    arg_d      = arg_q;
    div_d      = div_q;
    resp_d     = resp_q;
    resp_idx_d = resp_idx_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    crc_err_d  = crc_err_q;
    resp_en_d  = resp_en_q;
    ready_d    = i_request;
    rdata_d    = rdata_q;

    if (i_request && !i_rw) rdata_d = rd_mux;

    if (busy) begin
      if (tick) begin
        div_cnt_d = '0;
        sdclk_d   = ~sdclk_q;
      end else begin
        div_cnt_d = div_cnt_q + 8'd1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (wr_idle) begin
          unique case (i_address)
            2'd0: arg_d = i_wdata;
            2'd1: begin
              done_d    = 1'b0;
              timeout_d = 1'b0;
              crc_err_d = 1'b0;
              bit_cnt_d = '0;
              cmd_oe_d  = 1'b1;
              if (i_wdata[8]) begin
                state_d   = S_INIT;
                cmd_out_d = 1'b1;
              end else begin
                state_d   = S_SEND;
                resp_en_d = i_wdata[6];
                shreg_d   = frame;
                cmd_out_d = frame[47];
              end
            end
            2'd3: div_d = i_wdata[7:0];
            default: ;
          endcase
        end
      end
      S_INIT: begin
        if (rise) bit_cnt_d = bit_cnt_q + 7'd1;
        if (fall && bit_cnt_q == INIT_LAST) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          div_cnt_d = '0;
        end
      end
      S_SEND: begin
        if (fall) begin
          if (bit_cnt_q == 7'd47) begin
            bit_cnt_d = '0;
            cmd_out_d = 1'b1;
            if (resp_en_q) begin
              state_d  = S_WAIT;
              cmd_oe_d = 1'b0;
            end else begin
              state_d  = S_NCC;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
            shreg_d   = {shreg_q[46:0], 1'b0};
            cmd_out_d = shreg_q[46];
          end
        end
      end
      S_WAIT: begin
        if (rise) begin
          if (!SD_CMD_in) begin
            state_d   = S_RECV;
            shreg_d   = '0;
            bit_cnt_d = 7'd1;
          end else if (bit_cnt_q == TO_LAST) begin
            state_d   = S_NCC;
            timeout_d = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end
      end
      S_RECV: begin
        if (rise) begin
          shreg_d = rx;
          if (bit_cnt_q == 7'd47) begin
            state_d    = S_NCC;
            bit_cnt_d  = '0;
            resp_idx_d = rx[45:40];
            resp_d     = rx[39:8];
            crc_err_d  = resp_bad;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end
      end
      S_NCC: begin
        // card may still drive its last bit until the falling edge
        if (fall) begin
          cmd_oe_d  = 1'b1;
          cmd_out_d = 1'b1;
        end
        if (rise) bit_cnt_d = bit_cnt_q + 7'd1;
        if (fall && bit_cnt_q == NCC_LAST) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          div_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) sdclk_d = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      sdclk_q    <= 1'b0;
      cmd_out_q  <= 1'b1;
      cmd_oe_q   <= 1'b0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      arg_q      <= '0;
      div_q      <= DEFAULT_DIV;
      resp_q     <= '0;
      resp_idx_q <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      crc_err_q  <= 1'b0;
      resp_en_q  <= 1'b0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      sdclk_q    <= sdclk_d;
      cmd_out_q  <= cmd_out_d;
      cmd_oe_q   <= cmd_oe_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      arg_q      <= arg_d;
      div_q      <= div_d;
      resp_q     <= resp_d;
      resp_idx_q <= resp_idx_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      crc_err_q  <= crc_err_d;
      resp_en_q  <= resp_en_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
    end
  end

  assign o_rdata    = rdata_q;
  assign o_ready    = ready_q;
  assign SD_CLK     = sdclk_q;
  assign SD_CMD_out = cmd_out_q;
  assign SD_CMD_oe  = cmd_oe_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: directed cases plus random transactions
// against a card/register model.
module tb_sd_cmd_engine;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_request = 1'b0;
  logic        i_rw = 1'b0;
  logic [1:0]  i_address = '0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        SD_CLK;
  logic        SD_CMD_out;
  logic        SD_CMD_oe;
  logic        SD_CMD_in = 1'b1;

  sd_cmd_engine dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_request(i_request), .i_rw(i_rw),
    .i_address(i_address), .i_wdata(i_wdata),
    .o_rdata(o_rdata), .o_ready(o_ready),
    .SD_CLK(SD_CLK), .SD_CMD_out(SD_CMD_out),
    .SD_CMD_oe(SD_CMD_oe), .SD_CMD_in(SD_CMD_in)
  );

  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_err = 0;

  logic [31:0] m_arg, m_resp;
  logic [7:0]  m_div;
  logic [5:0]  m_idx;
  logic        m_done, m_to, m_crc;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [46:0] m;
    m = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m[i-:8] = m[i-:8] ^ 8'h89;
    return m[6:0];
  endfunction

  function automatic logic resp_err(input logic [47:0] f);
    logic e;
    e = ~f[0];
`ifdef SD_CMD_RESP_CRC_EN
    if (crc7_ref(f[47:8]) != f[7:1]) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] status_exp();
    return {10'b0, m_idx, 12'b0, m_crc, m_to, m_done, 1'b0};
  endfunction

  task automatic model_reset();
    m_arg = '0; m_resp = '0; m_div = 8'h7C; m_idx = '0;
    m_done = 0; m_to = 0; m_crc = 0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge i_clock);
    i_request = 1; i_rw = 1; i_address = a; i_wdata = d;
    @(negedge i_clock);
    i_request = 0; i_rw = 0;
    check("wr_ready", o_ready, 1);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge i_clock);
    i_request = 1; i_rw = 0; i_address = a;
    @(negedge i_clock);
    i_request = 0;
    d = o_rdata;
    check("rd_ready", o_ready, 1);
  endtask

  task automatic set_reg(input logic [1:0] a, input logic [31:0] d);
    bus_wr(a, d);
    if (a == 2'd0) m_arg = d;
    if (a == 2'd3) m_div = d[7:0];
  endtask

  task automatic apply_reset();
    @(negedge i_clock);
    i_reset = 0; i_request = 0; SD_CMD_in = 1;
    @(negedge i_clock);
    i_reset = 1;
    model_reset();
  endtask

  task automatic do_txn(
    input  logic [31:0] ctrl, input bit reply, input int delay,
    input  logic [47:0] rframe,
    input  logic [1:0]  ba, input logic [31:0] bd,
    output logic [47:0] cap, output logic [31:0] st,
    output logic [31:0] rsp
  );
    bit init, resp, fin, prev;
    int ncmd, nwait, ndrv, rises, falls, quiet, cyc, bad;
    logic [39:0] hdr;
    logic [47:0] exp_frame;
    logic [31:0] rd;
    init = ctrl[8];
    resp = ctrl[6] && !init;
    hdr = {2'b01, ctrl[5:0], m_arg};
    exp_frame = {hdr, crc7_ref(hdr), 1'b1};
    ncmd  = init ? 0 : 48;
    nwait = !resp ? 0 : (reply ? delay + 48 : 64);
    ndrv  = init ? 80 : 8;
    cap = '0;
    bus_wr(2'd1, ctrl);
    m_done = 0; m_to = 0; m_crc = 0;
    rises = 0; falls = 0; quiet = 0; cyc = 0; bad = 0;
    prev = 0; fin = 0;
    while (!fin) begin
      @(negedge i_clock);
      cyc++;
      if (cyc == 2) begin
        i_request = 1; i_rw = 1; i_address = ba; i_wdata = bd;
      end
      if (cyc == 3) begin
        check("busy_wr_ready", o_ready, 1);
        i_request = 0; i_rw = 0;
      end
      if (cyc == 4) check("busy_wr_ready_off", o_ready, 0);
      if (cyc == 6) begin
        i_request = 1; i_rw = 0; i_address = 2'd1;
      end
      if (cyc == 7) begin
        check("busy_flag", o_rdata[0], 1);
        i_request = 0;
      end
      if (SD_CLK !== prev) begin
        quiet = 0;
        if (SD_CLK === 1'b1) begin
          if (rises < ncmd) begin
            cap[47-rises] = SD_CMD_out;
            if (SD_CMD_oe !== 1'b1) bad++;
          end else if (rises < ncmd + nwait) begin
            if (SD_CMD_oe !== 1'b0) bad++;
          end else if (!(SD_CMD_oe === 1'b1 && SD_CMD_out === 1'b1)) begin
            bad++;
          end
          rises++;
        end else if (rises >= ncmd) begin
          if (resp && reply) begin
            if (falls >= delay && falls < delay + 48)
              SD_CMD_in = rframe[47-(falls-delay)];
            else
              SD_CMD_in = 1'b1;
          end
          falls++;
        end
      end else begin
        quiet++;
      end
      prev = SD_CLK;
      if (quiet > 4 * (int'(m_div) + 1) + 4) fin = 1;
      if (cyc > 30000) begin
        check("txn_budget", 1, 0);
        fin = 1;
      end
    end
    SD_CMD_in = 1'b1;
    m_done = 1;
    if (resp && !reply) m_to = 1;
    if (resp && reply) begin
      m_idx  = rframe[45:40];
      m_resp = rframe[39:8];
      m_crc  = resp_err(rframe);
    end
    check("sd_rises", rises, ncmd + nwait + ndrv);
    check("line_state", bad, 0);
    if (!init) check("cmd_frame", cap, exp_frame);
    check("sdclk_idle", SD_CLK, 0);
    bus_rd(2'd1, st);
    check("status", st, status_exp());
    bus_rd(2'd2, rsp);
    check("resp", rsp, m_resp);
    bus_rd(2'd0, rd);
    check("arg", rd, m_arg);
    bus_rd(2'd3, rd);
    check("div", rd, {24'b0, m_div});
  endtask

  function automatic logic [47:0] card_frame(input logic [5:0] idx,
                                             input logic [31:0] pay,
                                             input int kind);
    logic [47:0] f;
    f = {2'b00, idx, pay, 7'b0, 1'b1};
    f[7:1] = crc7_ref(f[47:8]);
    if (kind == 2) f[3] = ~f[3];
    if (kind == 3) f[0] = 1'b0;
    return f;
  endfunction

  logic [47:0] cap;
  logic [31:0] st, rsp, rd;

  initial begin
    model_reset();
    repeat (3) @(negedge i_clock);
    check("rst_sdclk", SD_CLK, 0);
    check("rst_oe", SD_CMD_oe, 0);
    check("rst_out", SD_CMD_out, 1);
    check("rst_ready", o_ready, 0);
    check("rst_rdata", o_rdata, 0);
    i_reset = 1;
    bus_rd(2'd1, rd); check("rst_status", rd, 32'h0);
    bus_rd(2'd3, rd); check("rst_div", rd, 32'h7C);
    bus_rd(2'd0, rd); check("rst_arg", rd, 32'h0);
    bus_rd(2'd2, rd); check("rst_resp", rd, 32'h0);

    set_reg(2'd3, 32'h0);
    set_reg(2'd0, 32'h0);
    do_txn(32'h000, 0, 0, '0, 2'd3, 32'h55, cap, st, rsp);
    check("cmd0_bytes", cap, 48'h400000000095);
    check("cmd0_status", st, 32'h2);

    set_reg(2'd3, 32'h1);
    set_reg(2'd0, 32'h1AA);
    do_txn(32'h048, 1, 3, 48'h08000001AA13, 2'd1, 32'h100,
           cap, st, rsp);
    check("cmd8_bytes", cap, 48'h48000001AA87);
    check("cmd8_resp", rsp, 32'h1AA);
    check("cmd8_status", st, 32'h00080002);

    do_txn(32'h048, 1, 3, 48'h08000001AA15, 2'd0, 32'h0,
           cap, st, rsp);
`ifdef SD_CMD_RESP_CRC_EN
    check("cmd8_bad_crc", st, 32'h0008000A);
`else
    check("cmd8_bad_crc", st, 32'h00080002);
`endif

    apply_reset();
    set_reg(2'd3, 32'h1);
    do_txn(32'h040, 0, 0, '0, 2'd3, 32'h9, cap, st, rsp);
    check("to_status", st, 32'h6);
    check("to_resp", rsp, 32'h0);

    do_txn(32'h1C5, 0, 0, '0, 2'd0, 32'hFFFFFFFF, cap, st, rsp);
    check("init_status", st, 32'h2);

    for (int n = 0; n < 10; n++) begin
      logic [31:0] ctrl;
      logic [1:0]  ba;
      bit          reply;
      int          kind;
      set_reg(2'd3, $urandom_range(0, 3));
      set_reg(2'd0, $urandom);
      ctrl = $urandom;
      ctrl[8] = ($urandom_range(0, 7) == 0);
      reply = ($urandom_range(0, 4) != 0);
      kind = $urandom_range(0, 3);
      ba = 2'($urandom_range(0, 2));
      if (ba == 2'd2) ba = 2'd3;
      do_txn(ctrl, reply, $urandom_range(0, 12),
             card_frame(6'($urandom), $urandom, kind),
             ba, $urandom, cap, st, rsp);
    end

    set_reg(2'd3, 32'h0);
    set_reg(2'd0, 32'h12345678);
    bus_wr(2'd1, 32'h048);
    repeat (40) @(negedge i_clock);
    i_reset = 0;
    @(negedge i_clock);
    check("abort_sdclk", SD_CLK, 0);
    check("abort_oe", SD_CMD_oe, 0);
    check("abort_out", SD_CMD_out, 1);
    i_reset = 1;
    model_reset();
    bus_rd(2'd1, rd); check("abort_status", rd, 32'h0);
    bus_rd(2'd3, rd); check("abort_div", rd, 32'h7C);
    bus_rd(2'd0, rd); check("abort_arg", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
